// File: rtl/aes_sched_pkg.sv
// Shared types and helpers for the AES request scheduler.
package aes_sched_pkg;

    localparam int AES_W        = 128;
    localparam int DEF_CORE_LAT = 20;
    localparam int MAX_NREQ     = 8;
    localparam int ID_W         = 3;

    // One entry of the in-flight tag pipe
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    // Result of a round-robin search
    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } rr_pick_t;

    // Search last+1, last+2, ... (wrapping) for the first valid requester.
    // Unused upper bits of 'valid' must be zero, which makes the modulo-8
    // walk visit the real requesters in the same order as a modulo-NREQ walk.
    function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                         input logic [ID_W-1:0]     last);
        rr_pick_t        pick;
        logic [ID_W-1:0] cand;
        pick = '0;
        for (int k = 1; k <= MAX_NREQ; k++) begin
            cand = last + ID_W'(k);
            if (!pick.found && valid[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered 'last granted' pointer.
module rr_arbiter
    import aes_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id,
    output logic            transfer
);

    logic [ID_W-1:0]     last_q;
    logic [ID_W-1:0]     last_d;
    logic [MAX_NREQ-1:0] valid_pad;
    rr_pick_t            pick;

    // Pick the next valid requester after 'last'; nothing is granted while disabled or in reset
    always_comb begin
        valid_pad           = '0;
        valid_pad[NREQ-1:0] = req_valid & {NREQ{en}};
        pick                = rr_pick(valid_pad, last_q);
        transfer            = pick.found & rst;
        grant_id            = pick.idx;
        grant               = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = transfer && (pick.idx == ID_W'(i));
        end
        last_d = transfer ? pick.idx : last_q;
    end

    // Pointer register; starts at the top index so requester 0 wins first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= ID_W'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/aes_req_sched.sv
// Shares one pipelined AES-128 core among NREQ requesters and routes each
// ciphertext back to its owner using a tag pipe matched to the core latency.
module aes_req_sched
    import aes_sched_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int CORE_LAT = DEF_CORE_LAT,
    localparam int CNT_W    = $clog2(CORE_LAT + 2) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AES_W-1:0] req_state,
    input  logic [NREQ*AES_W-1:0] req_key,
    output logic [AES_W-1:0]      core_state,
    output logic [AES_W-1:0]      core_key,
    input  logic [AES_W-1:0]      core_out,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [AES_W-1:0]      rsp_data,
    output logic [CNT_W-1:0]      inflight
);

    logic [ID_W-1:0]  grant_id;
    logic             transfer;
    logic             retire;

    logic [AES_W-1:0] core_state_q;
    logic [AES_W-1:0] core_state_d;
    logic [AES_W-1:0] core_key_q;
    logic [AES_W-1:0] core_key_d;
    tag_t             tag_q [CORE_LAT+1];
    tag_t             tag_d [CORE_LAT+1];
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] inflight_d;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .grant     (req_ready),
        .grant_id  (grant_id),
        .transfer  (transfer)
    );

    // Load the winner's block into the core inputs; hold them on idle cycles
    always_comb begin
        core_state_d = core_state_q;
        core_key_d   = core_key_q;
        for (int i = 0; i < NREQ; i++) begin
            if (transfer && (grant_id == ID_W'(i))) begin
                core_state_d = req_state[i*AES_W +: AES_W];
                core_key_d   = req_key[i*AES_W +: AES_W];
            end
        end
    end

    // Advance the tag pipe every edge and keep accepted-minus-retired count
    always_comb begin
        tag_d[0] = {transfer, grant_id};
        for (int k = 1; k <= CORE_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        retire     = tag_q[CORE_LAT].valid;
        inflight_d = inflight_q + CNT_W'(transfer) - CNT_W'(retire);
    end

    // Decode the oldest tag into the one-hot response owner
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = tag_q[CORE_LAT].valid && (tag_q[CORE_LAT].id == ID_W'(i));
        end
    end

    // State registers; reset discards everything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_state_q <= '0;
            core_key_q   <= '0;
            inflight_q   <= '0;
            for (int k = 0; k <= CORE_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            core_state_q <= core_state_d;
            core_key_q   <= core_key_d;
            inflight_q   <= inflight_d;
            for (int k = 0; k <= CORE_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign core_state = core_state_q;
    assign core_key   = core_key_q;
    assign inflight   = inflight_q;
    assign rsp_data   = core_out;

endmodule

// File: tb/tb_aes_req_sched.sv
// Directed bench for aes_req_sched driving a behavioural 20-stage AES-128 core.
module tb_aes_req_sched;
    import aes_sched_pkg::*;

    localparam int NREQ     = 4;
    localparam int CORE_LAT = 20;
    localparam int CNT_W    = $clog2(CORE_LAT + 2) + 1;

    localparam logic [127:0] PT0 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT0 = 128'h3925841d02dc09fbdc118597196a0b32;

    localparam logic [127:0] V_ST [4] = '{128'h00112233445566778899aabbccddeeff,
                                          128'h0, 128'h0, 128'h1};
    localparam logic [127:0] V_KY [4] = '{128'h000102030405060708090a0b0c0d0e0f,
                                          128'h0, 128'h1, 128'h0};
    localparam logic [127:0] V_CT [4] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                          128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                                          128'h0545aad56da2a97c3663d1432a3d1c84,
                                          128'h58e2fccefa7e3061367f1d57a4e7455a};

    logic                  clk;
    logic                  rst;
    logic                  en;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*AES_W-1:0] req_state;
    logic [NREQ*AES_W-1:0] req_key;
    logic [AES_W-1:0]      core_state;
    logic [AES_W-1:0]      core_key;
    logic [AES_W-1:0]      core_out;
    logic [NREQ-1:0]       rsp_valid;
    logic [AES_W-1:0]      rsp_data;
    logic [CNT_W-1:0]      inflight;

    int n_checks;
    int n_bad;
    int cyc;
    int stray;
    int exp_id;
    int rsp_seen;
    int grants [4];
    int resps  [4];

    logic [7:0]   sbox_t    [256];
    logic [127:0] core_pipe [CORE_LAT];

    aes_req_sched #(
        .NREQ     (NREQ),
        .CORE_LAT (CORE_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_state  (req_state),
        .req_key    (req_key),
        .core_state (core_state),
        .core_key   (core_key),
        .core_out   (core_out),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .inflight   (inflight)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box built from the GF(2^8) inverse and the affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] base;
        logic [7:0] e;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv  = 8'h01;
            base = x;
            e    = 8'd254;
            for (int i = 0; i < 8; i++) begin
                if (e[0]) inv = gmul(inv, base);
                base = gmul(base, base);
                e    = e >> 1;
            end
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   k [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127-8*i -: 8];
            k[i] = key[127-8*i -: 8];
            s[i] = s[i] ^ k[i];
        end
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            a0 = sbox_t[k[13]] ^ rc;
            a1 = sbox_t[k[14]];
            a2 = sbox_t[k[15]];
            a3 = sbox_t[k[12]];
            k[0] = k[0] ^ a0;
            k[1] = k[1] ^ a1;
            k[2] = k[2] ^ a2;
            k[3] = k[3] ^ a3;
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i + 4*(i%4)) % 16]];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c];
                    a1 = t[4*c+1];
                    a2 = t[4*c+2];
                    a3 = t[4*c+3];
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Core stand-in: samples state/key each edge, result appears CORE_LAT edges later
    always @(posedge clk) begin
        core_pipe[0] <= aes_enc(core_state, core_key);
        for (int k = 1; k < CORE_LAT; k++) core_pipe[k] <= core_pipe[k-1];
    end

    assign core_out = core_pipe[CORE_LAT-1];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [NREQ-1:0] valid, input logic en_in);
        req_valid = valid;
        en        = en_in;
        #1;
    endtask

    task automatic load_req(input int i, input logic [127:0] st, input logic [127:0] ky);
        req_state[i*AES_W +: AES_W] = st;
        req_key[i*AES_W +: AES_W]   = ky;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (rsp_valid == '0 && cycles < 60) begin
            tick();
            cycles++;
        end
    endtask

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_bad     = 0;
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        for (int i = 0; i < 4; i++) begin
            grants[i] = 0;
            resps[i]  = 0;
        end
        rsp_seen  = 0;
        rst       = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_state = '0;
        req_key   = '0;
        tick();
        tick();

        $display("[TB] reset state");
        check_output("rst_ready", 128'(req_ready), 128'd0);
        check_output("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        check_output("rst_inflight", 128'(inflight), 128'd0);
        check_output("rst_core_state", core_state, 128'd0);
        check_output("rst_core_key", core_key, 128'd0);
        rst = 1'b1;
        tick();

        // Single block on requester 0; response in the 21st cycle after the transfer cycle
        $display("[TB] single block");
        load_req(0, PT0, K0);
        apply_stimulus(4'b0001, 1'b1);
        check_output("t1_ready", 128'(req_ready), 128'd1);
        tick();
        apply_stimulus(4'b0000, 1'b1);
        check_output("t1_inflight", 128'(inflight), 128'd1);
        check_output("t1_core_state", core_state, PT0);
        check_output("t1_core_key", core_key, K0);
        wait_rsp(cyc);
        check_output("t1_latency", 128'(cyc), 128'd20);
        check_output("t1_rsp_valid", 128'(rsp_valid), 128'd1);
        check_output("t1_rsp_data", rsp_data, CT0);
        check_output("t1_inflight_ret", 128'(inflight), 128'd1);
        tick();
        check_output("t1_inflight_end", 128'(inflight), 128'd0);
        check_output("t1_rsp_idle", 128'(rsp_valid), 128'd0);

        // Back-to-back, one block from each requester in order 0..3
        $display("[TB] back-to-back");
        for (int i = 0; i < 4; i++) load_req(i, V_ST[i], V_KY[i]);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(4'(1 << i), 1'b1);
            check_output("t2_ready", 128'(req_ready), 128'(1) << i);
            tick();
        end
        apply_stimulus(4'b0000, 1'b1);
        check_output("t2_inflight", 128'(inflight), 128'd4);
        wait_rsp(cyc);
        check_output("t2_latency", 128'(cyc), 128'd17);
        for (int i = 0; i < 4; i++) begin
            check_output("t2_rsp_valid", 128'(rsp_valid), 128'(1) << i);
            check_output("t2_rsp_data", rsp_data, V_CT[i]);
            tick();
        end
        check_output("t2_rsp_idle", 128'(rsp_valid), 128'd0);
        check_output("t2_inflight_end", 128'(inflight), 128'd0);

        // Fairness: all valid for 40 cycles, grants rotate 0..3, responses in order
        $display("[TB] fairness");
        for (int c = 0; c < 66; c++) begin
            apply_stimulus((c < 40) ? 4'b1111 : 4'b0000, 1'b1);
            if (c < 40) check_output("t3_ready", 128'(req_ready), 128'(1) << (c % 4));
            for (int i = 0; i < 4; i++) if (req_ready[i]) grants[i]++;
            if (c == 20) check_output("t3_inflight_fill", 128'(inflight), 128'd20);
            if (c == 21 || c == 22 || c == 35) check_output("t3_inflight_full", 128'(inflight), 128'd21);
            if (rsp_valid != '0) begin
                exp_id = rsp_seen % 4;
                check_output("t3_rsp_valid", 128'(rsp_valid), 128'(1) << exp_id);
                check_output("t3_rsp_data", rsp_data, V_CT[exp_id]);
                for (int i = 0; i < 4; i++) if (rsp_valid[i]) resps[i]++;
                rsp_seen++;
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            check_output("t3_grants", 128'(grants[i]), 128'd10);
            check_output("t3_resps", 128'(resps[i]), 128'd10);
        end
        check_output("t3_inflight_end", 128'(inflight), 128'd0);

        // Gating: one grant, then en low for 5 cycles, then resume after 'last'
        $display("[TB] enable gating");
        apply_stimulus(4'b1111, 1'b1);
        check_output("t4_ready", 128'(req_ready), 128'd1);
        tick();
        for (int g = 0; g < 5; g++) begin
            apply_stimulus(4'b1111, 1'b0);
            check_output("t4_gated_ready", 128'(req_ready), 128'd0);
            check_output("t4_core_state", core_state, V_ST[0]);
            check_output("t4_core_key", core_key, V_KY[0]);
            check_output("t4_inflight", 128'(inflight), 128'd1);
            tick();
        end
        apply_stimulus(4'b1111, 1'b1);
        check_output("t4_resume_ready", 128'(req_ready), 128'd2);
        tick();
        apply_stimulus(4'b0000, 1'b1);
        check_output("t4_core_key_new", core_key, V_KY[1]);
        wait_rsp(cyc);
        check_output("t4_latency_a", 128'(cyc), 128'd14);
        check_output("t4_rsp_valid_a", 128'(rsp_valid), 128'd1);
        check_output("t4_rsp_data_a", rsp_data, V_CT[0]);
        tick();
        wait_rsp(cyc);
        check_output("t4_latency_b", 128'(cyc), 128'd5);
        check_output("t4_rsp_valid_b", 128'(rsp_valid), 128'd2);
        check_output("t4_rsp_data_b", rsp_data, V_CT[1]);
        tick();

        // Reset mid-flight: 3 transfers (grants 2,3,0), reset asserted at cycle 10
        $display("[TB] reset mid-flight");
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(4'b1111, 1'b1);
            check_output("t5_ready", 128'(req_ready), 128'(1) << ((i + 2) % 4));
            tick();
        end
        apply_stimulus(4'b0000, 1'b1);
        check_output("t5_inflight", 128'(inflight), 128'd3);
        for (int i = 0; i < 7; i++) tick();
        rst       = 1'b0;
        req_valid = 4'b1111;
        #1;
        check_output("t5_rst_ready", 128'(req_ready), 128'd0);
        check_output("t5_rst_rsp_valid", 128'(rsp_valid), 128'd0);
        check_output("t5_rst_inflight", 128'(inflight), 128'd0);
        check_output("t5_rst_core_state", core_state, 128'd0);
        check_output("t5_rst_core_key", core_key, 128'd0);
        tick();
        tick();
        req_valid = '0;
        rst       = 1'b1;
        stray     = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rsp_valid != '0) stray++;
        end
        check_output("t5_no_stray_rsp", 128'(stray), 128'd0);
        apply_stimulus(4'b1111, 1'b1);
        check_output("t5_ready_after", 128'(req_ready), 128'd1);
        tick();
        apply_stimulus(4'b0000, 1'b1);
        wait_rsp(cyc);
        check_output("t5_latency", 128'(cyc), 128'd20);
        check_output("t5_rsp_valid", 128'(rsp_valid), 128'd1);
        check_output("t5_rsp_data", rsp_data, V_CT[0]);
        tick();
        check_output("t5_inflight_end", 128'(inflight), 128'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
